// File: rtl/cp0_pkg.sv
// Shared constants for the coprocessor-0 interrupt/exception block:
// register numbers, STATUS/CAUSE field positions and ExcCode values.
package cp0_pkg;

    // CP0 register numbers
    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    // STATUS field positions
    localparam int ST_IE     = 0;
    localparam int ST_EXL    = 1;
    localparam int ST_IM_LO  = 8;
    localparam int ST_IM_HI  = 15;

    // CAUSE field positions
    localparam int CA_EXC_LO = 2;
    localparam int CA_EXC_HI = 6;
    localparam int CA_IP_LO  = 8;
    localparam int CA_IP_HI  = 15;

    // Exception codes written into CAUSE.ExcCode
    typedef enum logic [4:0] {
        EXC_INT = 5'd0,
        EXC_SYS = 5'd8,
        EXC_BP  = 5'd9,
        EXC_OV  = 5'd12,
        EXC_TEQ = 5'd13
    } exc_code_e;

    // Default handler entry address
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0040_0004;

endpackage

// File: rtl/cp0_status_stack.sv
// LIFO of saved STATUS words for nested exceptions. Push is ignored when
// full and pop is ignored when empty; top is only meaningful when not empty.
// Reset discards the contents by clearing the depth counter.
module cp0_status_stack #(
    parameter int STACK_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] din,
    output logic [31:0] top,
    output logic        full,
    output logic        empty
);

    localparam int PW = $clog2(STACK_DEPTH);

    logic [31:0] mem [STACK_DEPTH];
    logic [PW:0] depth;
    logic [PW-1:0] wr_idx;
    logic [PW-1:0] top_idx;

    assign full    = (depth == (PW+1)'(STACK_DEPTH));
    assign empty   = (depth == '0);
    assign wr_idx  = depth[PW-1:0];
    assign top_idx = wr_idx - PW'(1);
    assign top     = mem[top_idx];

    // Occupancy counter: the only state that reset needs to clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth <= '0;
        end else if (push && !full) begin
            depth <= depth + (PW+1)'(1);
        end else if (pop && !empty) begin
            depth <= depth - (PW+1)'(1);
        end
    end

    // Storage array, written at the current depth on a successful push
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/cp0_intc.sv
// Coprocessor 0: STATUS/CAUSE/EPC, COUNT/COMPARE timer, external interrupt
// sampling and a STATUS save stack for nested exceptions. Per-cycle update
// priority is exception > eret > mtc0.
module cp0_intc
    import cp0_pkg::*;
#(
    parameter int          NUM_IRQ     = 5,
    parameter int          STACK_DEPTH = 4,
    parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEF,
    parameter logic [31:0] STATUS_RST  = 32'h0000_FF01
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mfc0,
    input  logic               mtc0,
    input  logic [4:0]         addr,
    input  logic [31:0]        wdata,
    input  logic [31:0]        pc,
    input  logic               exception,
    input  logic [4:0]         cause,
    input  logic               eret,
    input  logic [NUM_IRQ-1:0] irq,
    output logic [31:0]        rdata,
    output logic [31:0]        status,
    output logic [31:0]        epc_out,
    output logic               int_req,
    output logic               nest_ovf
);

    logic [31:0]        status_q;
    logic [31:0]        epc_q;
    logic [31:0]        count_q;
    logic [31:0]        compare_q;
    logic [4:0]         exc_q;
    logic               timer_q;
    logic [NUM_IRQ-1:0] irq_q;
    logic               ovf_q;

    logic [31:0] stack_top;
    logic        stack_full;
    logic        stack_empty;
    logic        stack_push;
    logic        stack_pop;

    logic        wr_en;
    logic        wr_count;
    logic        wr_compare;
    logic [7:0]  ip;
    logic [31:0] cause_word;

    // mtc0 only lands when neither exception nor eret claims the cycle
    assign wr_en      = mtc0 & ~exception & ~eret;
    assign wr_count   = wr_en & (addr == REG_COUNT);
    assign wr_compare = wr_en & (addr == REG_COMPARE);

    assign stack_push = exception & ~stack_full;
    assign stack_pop  = eret & ~exception & ~stack_empty;

    cp0_status_stack #(
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (stack_push),
        .pop   (stack_pop),
        .din   (status_q),
        .top   (stack_top),
        .full  (stack_full),
        .empty (stack_empty)
    );

    // Pending-interrupt byte: timer in IP7, external lines from IP0 upward
    always_comb begin
        ip              = '0;
        ip[NUM_IRQ-1:0] = irq_q;
        ip[7]           = timer_q;
    end

    assign cause_word = {16'h0000, ip, 1'b0, exc_q, 2'b00};

    // Exception entry / return and software writes to STATUS, CAUSE, EPC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q <= STATUS_RST;
            epc_q    <= '0;
            exc_q    <= '0;
            ovf_q    <= 1'b0;
        end else if (exception) begin
            epc_q            <= pc;
            exc_q            <= cause;
            status_q[ST_IE]  <= 1'b0;
            status_q[ST_EXL] <= 1'b1;
            if (stack_full) begin
                ovf_q <= 1'b1;
            end
        end else if (eret) begin
            if (!stack_empty) begin
                status_q <= stack_top;
            end
        end else if (mtc0) begin
            case (addr)
                REG_STATUS: status_q <= wdata;
                REG_CAUSE:  exc_q    <= wdata[CA_EXC_HI:CA_EXC_LO];
                REG_EPC:    epc_q    <= wdata;
                default:    ;
            endcase
        end
    end

    // Free-running counter, compare match flag and external line sampling
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            compare_q <= 32'hFFFF_FFFF;
            timer_q   <= 1'b0;
            irq_q     <= '0;
        end else begin
            count_q <= wr_count ? wdata : count_q + 32'd1;
            if (wr_compare) begin
                compare_q <= wdata;
                timer_q   <= 1'b0;
            end else if (count_q == compare_q) begin
                timer_q <= 1'b1;
            end
            irq_q <= irq;
        end
    end

    // mfc0 read mux; unmapped registers read as zero
    always_comb begin
        rdata = '0;
        if (mfc0) begin
            case (addr)
                REG_COUNT:   rdata = count_q;
                REG_COMPARE: rdata = compare_q;
                REG_STATUS:  rdata = status_q;
                REG_CAUSE:   rdata = cause_word;
                REG_EPC:     rdata = epc_q;
                default:     rdata = '0;
            endcase
        end
    end

    assign status   = status_q;
    assign nest_ovf = ovf_q;
    assign epc_out  = eret ? epc_q : EXC_VECTOR;
    assign int_req  = status_q[ST_IE] & ~status_q[ST_EXL]
                    & |(ip & status_q[ST_IM_HI:ST_IM_LO]);

endmodule
